// File: rtl/usr_seq_ctrl.sv
// Sequencer that runs an external WIDTH-bit universal shift register as a P2S/S2P converter.
// Optional parity beat after each word is enabled by defining USR_CTRL_PARITY_EN.
module usr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic             sdo_o,
    output logic             sdo_valid_o,
    input  logic             sdo_ready_i,
    input  logic             sdi_i,
    input  logic             sdi_valid_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic [1:0]       usr_sel_o,
    output logic             usr_left_in_o,
    output logic             usr_right_in_o,
    output logic [WIDTH-1:0] usr_parallel_in_o,
    input  logic [WIDTH-1:0] usr_q_i
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_SHIFT = 2'd2, S_RESP = 2'd3} state_e;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_DN   = 2'b01;
    localparam logic [1:0] SEL_UP   = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

`ifdef USR_CTRL_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   stage_q, stage_d;
`ifdef USR_CTRL_PARITY_EN
    logic               par_q, par_d;
    logic               err_q, err_d;
`endif

    logic is_rx_s, is_msb_s, beat_s, last_s, par_beat_s, tx_bit_s;

    assign is_rx_s  = op_q[1];
    assign is_msb_s = op_q[0];
    assign beat_s   = (state_q == S_SHIFT) && (is_rx_s ? sdi_valid_i : sdo_ready_i);
    assign last_s   = (cnt_q == LAST_CNT);
    assign tx_bit_s = is_msb_s ? usr_q_i[WIDTH-1] : usr_q_i[0];
`ifdef USR_CTRL_PARITY_EN
    assign par_beat_s = (cnt_q == CNT_W'(WIDTH));
`else
    assign par_beat_s = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            cnt_q   <= {CNT_W{1'b0}};
            stage_q <= {WIDTH{1'b0}};
`ifdef USR_CTRL_PARITY_EN
            par_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
`ifdef USR_CTRL_PARITY_EN
            par_q   <= par_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and register update decode
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
`ifdef USR_CTRL_PARITY_EN
        par_d   = par_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    cnt_d   = {CNT_W{1'b0}};
                    stage_d = cmd_data_i;
`ifdef USR_CTRL_PARITY_EN
                    par_d   = 1'b0;
                    err_d   = 1'b0;
`endif
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: state_d = S_SHIFT;
            S_SHIFT: begin
                if (beat_s) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef USR_CTRL_PARITY_EN
                    if (par_beat_s) begin
                        err_d = is_rx_s ? (sdi_i ^ par_q) : 1'b0;
                    end else begin
                        par_d = par_q ^ (is_rx_s ? sdi_i : tx_bit_s);
                    end
`endif
                    if (last_s) begin
                        state_d = is_rx_s ? S_RESP : S_IDLE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; the parity beat never shifts the register
    always_comb begin
        cmd_ready_o       = 1'b0;
        sdo_o             = 1'b0;
        sdo_valid_o       = 1'b0;
        rsp_valid_o       = 1'b0;
        rsp_data_o        = {WIDTH{1'b0}};
        rsp_err_o         = 1'b0;
        usr_sel_o         = SEL_HOLD;
        usr_left_in_o     = 1'b0;
        usr_right_in_o    = 1'b0;
        usr_parallel_in_o = {WIDTH{1'b0}};
        case (state_q)
            S_IDLE: cmd_ready_o = 1'b1;
            S_LOAD: begin
                usr_sel_o         = SEL_LOAD;
                usr_parallel_in_o = is_rx_s ? {WIDTH{1'b0}} : stage_q;
            end
            S_SHIFT: begin
                if (!is_rx_s) begin
                    sdo_valid_o = 1'b1;
`ifdef USR_CTRL_PARITY_EN
                    sdo_o = par_beat_s ? par_q : tx_bit_s;
`else
                    sdo_o = tx_bit_s;
`endif
                    if (sdo_ready_i && !par_beat_s) begin
                        usr_sel_o = is_msb_s ? SEL_UP : SEL_DN;
                    end else begin
                        usr_sel_o = SEL_HOLD;
                    end
                end else if (sdi_valid_i && !par_beat_s) begin
                    if (is_msb_s) begin
                        usr_right_in_o = sdi_i;
                        usr_sel_o      = SEL_UP;
                    end else begin
                        usr_left_in_o  = sdi_i;
                        usr_sel_o      = SEL_DN;
                    end
                end else begin
                    usr_sel_o = SEL_HOLD;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = usr_q_i;
`ifdef USR_CTRL_PARITY_EN
                rsp_err_o   = err_q;
`else
                rsp_err_o   = 1'b0;
`endif
            end
            default: cmd_ready_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Self-checking bench for usr_seq_ctrl with a behavioural universal shift register attached.
module tb_usr_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
`ifdef USR_CTRL_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             sdo, sdo_valid, sdo_ready;
    logic             sdi, sdi_valid;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       usr_sel;
    logic             usr_left_in, usr_right_in;
    logic [WIDTH-1:0] usr_parallel_in;
    logic [WIDTH-1:0] reg_q;

    int checks = 0;
    int failures = 0;

    usr_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op), .cmd_data_i(cmd_data),
        .sdo_o(sdo), .sdo_valid_o(sdo_valid), .sdo_ready_i(sdo_ready),
        .sdi_i(sdi), .sdi_valid_i(sdi_valid),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .usr_sel_o(usr_sel), .usr_left_in_o(usr_left_in), .usr_right_in_o(usr_right_in),
        .usr_parallel_in_o(usr_parallel_in), .usr_q_i(reg_q)
    );

    always #5 clk = ~clk;

    // Universal shift register the controller drives
    always_ff @(posedge clk) begin
        if (reset) reg_q <= '0;
        else begin
            case (usr_sel)
                2'b01:   reg_q <= {usr_left_in, reg_q[WIDTH-1:1]};
                2'b10:   reg_q <= {reg_q[WIDTH-2:0], usr_right_in};
                2'b11:   reg_q <= usr_parallel_in;
                default: reg_q <= reg_q;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge with the controller idle.
    task automatic run_cmd(input logic [1:0] op, input logic [WIDTH-1:0] word,
                           input int stall_pct, input int stall_beat, input int stall_len,
                           input int rsp_wait, input logic par_bit, input logic hold_next,
                           input logic [1:0] next_op, input logic [WIDTH-1:0] next_word);
        logic             is_rx;
        logic [WIDTH:0]   exp_bits;
        logic [WIDTH-1:0] exp_word;
        logic             exp_err;
        logic [1:0]       dir_sel, exp_sel;
        logic             go;
        int beats, stalled, cyc, waitc;
        is_rx   = op[1];
        dir_sel = op[0] ? 2'b10 : 2'b01;
        for (int i = 0; i < WIDTH; i++) begin
            exp_bits[i] = op[0] ? word[WIDTH-1-i] : word[i];
            if (op[0]) exp_word[WIDTH-1-i] = word[i];
            else       exp_word[i] = word[i];
        end
        exp_bits[WIDTH] = ^word;
`ifdef USR_CTRL_PARITY_EN
        exp_err = par_bit ^ (^word);
`else
        exp_err = 1'b0;
`endif
        cmd_valid = 1'b1; cmd_op = op; cmd_data = word;
        sdo_ready = 1'b0; sdi_valid = 1'b0; rsp_ready = 1'b0;
        waitc = 0;
        while (!cmd_ready && waitc < 100) begin
            @(negedge clk); #1; waitc++;
        end
        check_eq("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold_next) begin
            cmd_op = next_op; cmd_data = next_word;
        end else begin
            cmd_valid = 1'b0;
        end
        #1;
        check_eq("load_sel", {30'd0, usr_sel}, 32'd3);
        check_eq("load_pin", {28'd0, usr_parallel_in}, is_rx ? 32'd0 : {28'd0, word});
        check_eq("load_ready", {31'd0, cmd_ready}, 32'd0);
        beats = 0; stalled = 0; cyc = 1;
        while (beats < NB && cyc < 200) begin
            @(negedge clk); cyc++;
            go = 1'b1;
            if (beats == stall_beat && stalled < stall_len) begin
                go = 1'b0; stalled++;
            end else if (int'($urandom_range(99)) < stall_pct) begin
                go = 1'b0;
            end
            if (is_rx) begin
                sdi_valid = go;
                sdi = go ? ((beats < WIDTH) ? word[beats] : par_bit) : 1'($urandom);
            end else begin
                sdo_ready = go;
            end
            #1;
            exp_sel = (!go || beats >= WIDTH) ? 2'b00 : dir_sel;
            check_eq("busy_ready", {31'd0, cmd_ready}, 32'd0);
            check_eq(is_rx ? "rx_sel" : "tx_sel", {30'd0, usr_sel}, {30'd0, exp_sel});
            if (!is_rx) begin
                check_eq("sdo_valid", {31'd0, sdo_valid}, 32'd1);
                if (go) check_eq("sdo_bit", {31'd0, sdo}, {31'd0, exp_bits[beats]});
            end else begin
                check_eq("rx_sdo_valid", {31'd0, sdo_valid}, 32'd0);
                check_eq("rx_early_rsp", {31'd0, rsp_valid}, 32'd0);
            end
            if (go) beats++;
        end
        check_eq("beats_done", beats, NB);
        if (stall_pct == 0 && stall_len == 0) check_eq("latency", cyc, NB + 1);
        @(negedge clk);
        sdo_ready = 1'b0; sdi_valid = 1'b0; sdi = 1'b0;
        #1;
        if (!is_rx) begin
            check_eq("tx_done_ready", {31'd0, cmd_ready}, 32'd1);
            check_eq("tx_done_sdo_valid", {31'd0, sdo_valid}, 32'd0);
            check_eq("tx_done_sdo", {31'd0, sdo}, 32'd0);
        end else begin
            check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("rsp_data", {28'd0, rsp_data}, {28'd0, exp_word});
            check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            check_eq("rsp_sel", {30'd0, usr_sel}, 32'd0);
            for (int k = 0; k < rsp_wait; k++) begin
                @(negedge clk); #1;
                check_eq("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
                check_eq("rsp_hold_data", {28'd0, rsp_data}, {28'd0, exp_word});
                check_eq("rsp_hold_ready", {31'd0, cmd_ready}, 32'd0);
            end
            @(negedge clk); rsp_ready = 1'b1; #1;
            check_eq("rsp_hs_valid", {31'd0, rsp_valid}, 32'd1);
            @(negedge clk); rsp_ready = 1'b0; #1;
            check_eq("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
            check_eq("rsp_done_ready", {31'd0, cmd_ready}, 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]       rop;
        logic [WIDTH-1:0] rword;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        sdo_ready = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk); #1;
        check_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_sdo_valid", {31'd0, sdo_valid}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_sel", {30'd0, usr_sel}, 32'd0);
        check_eq("rst_misc", {22'd0, sdo, rsp_err, usr_left_in, usr_right_in, rsp_data, usr_parallel_in}, 32'd0);
        @(negedge clk); reset = 1'b0; #1;

        run_cmd(2'b00, 4'b1011, 0, -1, 0, 0, 1'b0, 1'b0, 2'b00, 4'h0);
        run_cmd(2'b01, 4'b1011, 0, 1, 3, 0, 1'b0, 1'b0, 2'b00, 4'h0);
        run_cmd(2'b10, 4'b1001, 0, -1, 0, 5, 1'b0, 1'b0, 2'b00, 4'h0);
        run_cmd(2'b11, 4'b1001, 0, -1, 0, 2, 1'b0, 1'b1, 2'b00, 4'b0110);
        run_cmd(2'b00, 4'b0110, 0, -1, 0, 0, 1'b0, 1'b0, 2'b00, 4'h0);

        // Reset on the second shift beat of a transmit
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1011; sdo_ready = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; sdo_ready = 1'b0; #1;
        check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("mid_rst_sdo_valid", {31'd0, sdo_valid}, 32'd0);
        check_eq("mid_rst_reg", {28'd0, reg_q}, 32'd0);
        check_eq("mid_rst_sel", {30'd0, usr_sel}, 32'd0);

`ifdef USR_CTRL_PARITY_EN
        run_cmd(2'b00, 4'b0111, 0, -1, 0, 0, 1'b0, 1'b0, 2'b00, 4'h0);
        run_cmd(2'b10, 4'b0011, 0, -1, 0, 1, 1'b1, 1'b0, 2'b00, 4'h0);
`endif

        for (int n = 0; n < 24; n++) begin
            rop   = 2'($urandom);
            rword = WIDTH'($urandom);
            run_cmd(rop, rword, 30, -1, 0, int'($urandom_range(3)), 1'($urandom), 1'b0, 2'b00, 4'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usr_seq_ctrl.md
# usr_seq_ctrl

Sequencing controller for the 4-bit universal shift register in the serial-link datapath. Accepts transmit and receive commands over a valid/ready interface, drives the register's mode select, serial inputs and parallel load, and runs the register as a parallel-to-serial or serial-to-parallel converter. Received words are returned on a valid/ready response port. The register itself stays a separate instance; this block only owns its control pins.

## Interface
- WIDTH, 4: register width and bits per transaction; ≥2.
- CNT_W, 3: bit-counter width; must satisfy 2^CNT_W > WIDTH (+1 when parity is compiled in).
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; shared with the register instance.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle; command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 TX_LSB, 01 TX_MSB, 10 RX_LSB, 11 RX_MSB.
- cmd_data  in  WIDTH  TX word; ignored for RX.
- sdo  out  1  serial data out.
- sdo_valid  out  1  sdo holds a TX bit.
- sdo_ready  in  1  sink takes sdo this cycle.
- sdi  in  1  serial data in.
- sdi_valid  in  1  sdi holds an RX bit this cycle.
- rsp_valid  out  1  RX word available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WIDTH  received word (= usr_q while rsp_valid).
- rsp_err  out  1  parity error; constant 0 without USR_CTRL_PARITY_EN.
- usr_sel  out  2  to register: 00 hold, 01 shift toward bit 0 (left_in enters MSB), 10 shift toward MSB (right_in enters bit 0), 11 parallel load.
- usr_left_in  out  1  to register serial_left_in.
- usr_right_in  out  1  to register serial_right_in.
- usr_parallel_in  out  WIDTH  to register parallel_in.
- usr_q  in  WIDTH  from register parallel_data_out.

## Operation
- FSM states: IDLE, LOAD, SHIFT, RESP. Registers: state, op (2 b), bit_cnt (CNT_W), parity accumulator.
- IDLE: cmd_ready=1, usr_sel=00. On accept: op <- cmd_op, bit_cnt <- 0, capture cmd_data into a staging register, go to LOAD.
- LOAD (1 cycle): usr_sel=11, usr_parallel_in = staging for TX, all zeros for RX. Go to SHIFT.
- SHIFT, TX ops: sdo_valid=1; sdo = usr_q[0] (TX_LSB) or usr_q[WIDTH-1] (TX_MSB). When sdo_ready=1: usr_sel=01 (TX_LSB) or 10 (TX_MSB), and bit_cnt increments. When sdo_ready=0: usr_sel=00. The beat with bit_cnt==WIDTH-1 goes to IDLE.
- SHIFT, RX ops: sdo_valid=0. When sdi_valid=1: RX_LSB drives usr_left_in=sdi with usr_sel=01; RX_MSB drives usr_right_in=sdi with usr_sel=10. bit_cnt increments. When sdi_valid=0: usr_sel=00. The beat with bit_cnt==WIDTH-1 goes to RESP.
- RESP: usr_sel=00, rsp_valid=1, rsp_data=usr_q. rsp_valid && rsp_ready goes to IDLE.
- RX bit order: RX_LSB yields first bit at usr_q[0]; RX_MSB yields first bit at usr_q[WIDTH-1].
- usr_left_in and usr_right_in are 0 except where stated above. sdo is 0 when sdo_valid=0.
- All outputs decode combinationally from state, op and handshake inputs. There is no combinational path from cmd_valid to any output.

## Timing
- After the first reset edge: IDLE, cmd_ready=1, every other output 0, usr_sel=00. The register is cleared by the same reset.
- Reset asserted mid-transaction: back to IDLE at that edge. A pending command or response is dropped.
- TX latency with sdo_ready tied high: accept at cycle T, LOAD at T+1, bits on T+2..T+1+WIDTH, cmd_ready=1 at T+2+WIDTH. Back-to-back throughput is WIDTH+2 cycles per command.
- RX with sdi_valid tied high: rsp_valid=1 at T+2+WIDTH. Response holds indefinitely until rsp_ready.
- Stalls (sdo_ready=0 or sdi_valid=0) may last any number of cycles. The register holds and bit_cnt does not advance.
- A cmd_valid presented while busy is held off by cmd_ready=0. The command must remain stable until accepted.
- bit_cnt never wraps: the terminal beat exits SHIFT.

## Configuration
- USR_CTRL_PARITY_EN defined:
  - SHIFT runs WIDTH+1 beats. The parity accumulator XORs every data bit.
  - TX: the extra beat drives sdo = even parity of the word, with usr_sel=00 (register not shifted).
  - RX: the extra sdi beat is compared against the accumulated parity, again with usr_sel=00. rsp_err = mismatch, valid with rsp_valid.
- USR_CTRL_PARITY_EN undefined: WIDTH beats, no parity logic, rsp_err tied 0.

## Test plan
- Reset, then TX_LSB 4'b1011 with sdo_ready=1 -> sdo sequence 1,1,0,1 on cycles T+2..T+5; cmd_ready=1 at T+6.
- TX_MSB 4'b1011 with sdo_ready low on the 2nd beat for 3 cycles -> sdo 1,0(held 3 cycles, then taken),1,1; usr_sel=00 during the stall.
- RX_LSB with sdi 1,0,0,1 -> rsp_data=4'b1001. RX_MSB with the same bits -> rsp_data=4'b1001 (first bit at MSB). rsp_valid holds while rsp_ready=0 for 5 cycles.
- Back-to-back: RX_MSB then TX_LSB offered while busy -> second accepted only after the RESP handshake; no overlap on usr_sel.
- Reset asserted at 2nd SHIFT beat of TX -> next cycle IDLE, sdo_valid=0, usr_q=0, cmd_ready=1.
- With USR_CTRL_PARITY_EN: TX 4'b0111 -> 5th beat sdo=1. RX bits 1,1,0,0 with parity bit 1 -> rsp_err=1.
